// File: rtl/alu_unit.sv
// Integer ALU (ADD/SUB/AND/OR) with NZCV flags; one-cycle registered latency, out_valid qualifier.
// No backpressure: the consumer must capture result/flags on the cycle out_valid is high.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  input  logic             in_valid,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] result,
  output logic             out_valid
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic             core_v;
  logic [3:0]       core_flags;

  // SUB reuses the adder as a + ~b + 1, so C=1 means no borrow.
  assign b_eff   = control[0] ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, control[0]};

  always_comb begin
    core_res = '0;
    core_c   = 1'b0;
    core_v   = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        core_res = sum_ext[WIDTH-1:0];
        core_c   = sum_ext[WIDTH];
        core_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (core_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: core_res = a & b;
      OP_OR:  core_res = a | b;
      default: core_res = '0;
    endcase
  end

  assign core_flags = {core_res[WIDTH-1], (core_res == '0), core_c, core_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= core_res;
        flags  <= core_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit at WIDTH=4 against an arithmetic reference model.
module tb_alu_unit;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   control;
  logic         in_valid;
  logic [3:0]   flags;
  logic [W-1:0] result;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_res;
  logic [3:0]   last_flags;

  alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .control(control),
    .in_valid(in_valid), .flags(flags), .result(result), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {N,Z,C,V,result} from plain integer arithmetic.
  function automatic logic [W+3:0] ref_op(input int ai, input int bi, input int op);
    int r, sa, sb, full, sfull;
    logic n, z, c, v;
    logic [31:0] rv;
    sa = (ai >= HALF) ? ai - MOD : ai;
    sb = (bi >= HALF) ? bi - MOD : bi;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      0: begin
        full = ai + bi; r = full % MOD; c = (full >= MOD);
        sfull = sa + sb; v = (sfull > HALF - 1) || (sfull < -HALF);
      end
      1: begin
        full = ai - bi; r = (full + MOD) % MOD; c = (ai >= bi);
        sfull = sa - sb; v = (sfull > HALF - 1) || (sfull < -HALF);
      end
      2: r = ai & bi;
      default: r = ai | bi;
    endcase
    n = (r >= HALF);
    z = (r == 0);
    rv = r;
    return {n, z, c, v, rv[W-1:0]};
  endfunction

  // Drive one operation at the falling edge, then land #1 after the next rising edge.
  task automatic apply(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [1:0] op, input logic vld);
    @(negedge clk);
    a = ai; b = bi; control = op; in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; control = 2'b00;
    #1;
    checks++;
    if (result !== '0 || flags !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got res=%b flags=%b vld=%b, want 0000/0000/0", result, flags, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== '0 || flags !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got res=%b flags=%b vld=%b, want 0000/0000/0", result, flags, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [W-1:0] ta [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0100};
    logic [W-1:0] tb [4] = '{4'b1110, 4'b0000, 4'b1111, 4'b0101};
    logic [W-1:0] tr [4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1001};
    logic [3:0]   tf [4] = '{4'b1000, 4'b0100, 4'b0110, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      apply(ta[i], tb[i], 2'b00, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || result !== tr[i] || flags !== tf[i]) begin
        errors++;
        $display("FAIL add_%0d: got vld=%b res=%b nzcv=%b, want 1/%b/%b", i, out_valid, result, flags, tr[i], tf[i]);
      end
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] ta [5] = '{4'b0010, 4'b0000, 4'b0111, 4'b0100, 4'b0111};
    logic [W-1:0] tb [5] = '{4'b0001, 4'b1101, 4'b0010, 4'b0010, 4'b1000};
    logic [W-1:0] tr [5] = '{4'b0001, 4'b0011, 4'b0101, 4'b0010, 4'b1111};
    logic [W+3:0] exp;
    for (int i = 0; i < 5; i++) begin
      apply(ta[i], tb[i], 2'b01, 1'b1);
      exp = ref_op(int'(ta[i]), int'(tb[i]), 1);
      checks++;
      if (out_valid !== 1'b1 || result !== tr[i] || flags !== exp[W+3:W]) begin
        errors++;
        $display("FAIL sub_%0d: got vld=%b res=%b nzcv=%b, want 1/%b/%b", i, out_valid, result, flags, tr[i], exp[W+3:W]);
      end
    end
    // Spot-check the flag bits the directed cases call out.
    apply(4'b0010, 4'b0001, 2'b01, 1'b1);
    checks++;
    if (flags[1] !== 1'b1) begin
      errors++; $display("FAIL sub_c_noborrow: got C=%b, want 1", flags[1]);
    end
    apply(4'b0000, 4'b1101, 2'b01, 1'b1);
    checks++;
    if (flags[1] !== 1'b0) begin
      errors++; $display("FAIL sub_c_borrow: got C=%b, want 0", flags[1]);
    end
    apply(4'b0111, 4'b1000, 2'b01, 1'b1);
    checks++;
    if (flags[0] !== 1'b1) begin
      errors++; $display("FAIL sub_v: got V=%b, want 1", flags[0]);
    end
  endtask

  task automatic test_logic;
    logic [1:0]   to [6] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [W-1:0] ta [6] = '{4'b0100, 4'b0110, 4'b0001, 4'b1001, 4'b0111, 4'b0011};
    logic [W-1:0] tb [6] = '{4'b0010, 4'b0010, 4'b1110, 4'b0101, 4'b0100, 4'b0011};
    logic [W-1:0] tr [6] = '{4'b0000, 4'b0010, 4'b1111, 4'b1101, 4'b0111, 4'b0011};
    logic [3:0] want;
    for (int i = 0; i < 6; i++) begin
      apply(ta[i], tb[i], to[i], 1'b1);
      want = {tr[i][W-1], (tr[i] == '0), 2'b00};
      checks++;
      if (out_valid !== 1'b1 || result !== tr[i] || flags !== want) begin
        errors++;
        $display("FAIL logic_%0d: got vld=%b res=%b nzcv=%b, want 1/%b/%b", i, out_valid, result, flags, tr[i], want);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W+3:0] exp;
    logic [W-1:0] ra, rb;
    logic [1:0]   op;
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom_range(0, MOD - 1));
      rb = W'($urandom_range(0, MOD - 1));
      op = 2'($urandom_range(0, 3));
      apply(ra, rb, op, 1'b1);
      exp = ref_op(int'(ra), int'(rb), int'(op));
      checks++;
      if (out_valid !== 1'b1 || {flags, result} !== exp) begin
        errors++;
        $display("FAIL b2b_%0d: got vld=%b nzcv/res=%b, want 1/%b", i, out_valid, {flags, result}, exp);
      end
      last_res = exp[W-1:0];
      last_flags = exp[W+3:W];
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 3; i++) begin
      apply(W'($urandom_range(0, MOD - 1)), W'($urandom_range(0, MOD - 1)), 2'($urandom_range(0, 3)), 1'b0);
      checks++;
      if (out_valid !== 1'b0 || result !== last_res || flags !== last_flags) begin
        errors++;
        $display("FAIL hold_%0d: got vld=%b res=%b nzcv=%b, want 0/%b/%b", i, out_valid, result, flags, last_res, last_flags);
      end
    end
  endtask

  task automatic test_random;
    logic [W+3:0] exp;
    logic [W-1:0] ra, rb;
    logic [1:0]   op;
    logic         vld;
    exp = {last_flags, last_res};
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, MOD - 1));
      rb = W'($urandom_range(0, MOD - 1));
      op = 2'($urandom_range(0, 3));
      vld = ($urandom_range(0, 3) != 0);
      apply(ra, rb, op, vld);
      if (vld) exp = ref_op(int'(ra), int'(rb), int'(op));
      checks++;
      if (out_valid !== vld || {flags, result} !== exp) begin
        errors++;
        $display("FAIL rand_%0d: got vld=%b nzcv/res=%b, want %b/%b", i, out_valid, {flags, result}, vld, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [W+3:0] exp;
    apply(4'b0101, 4'b0011, 2'b00, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 4'b1000) begin
      errors++;
      $display("FAIL arst_pre: got vld=%b res=%b, want 1/1000", out_valid, result);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== '0 || flags !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: got res=%b flags=%b vld=%b, want 0000/0000/0", result, flags, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== '0 || flags !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_held: got res=%b flags=%b vld=%b, want 0000/0000/0", result, flags, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    apply(4'b0111, 4'b0010, 2'b01, 1'b1);
    exp = ref_op(7, 2, 1);
    checks++;
    if (out_valid !== 1'b1 || {flags, result} !== exp) begin
      errors++;
      $display("FAIL arst_after: got vld=%b nzcv/res=%b, want 1/%b", out_valid, {flags, result}, exp);
    end
  endtask

  initial begin
    last_res = '0;
    last_flags = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_hold();
    test_random();
    test_async_reset();
    @(negedge clk);
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
